// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: arbitrates several requesters onto one shared 32-bit ALU.
// The winner's operands and op code are registered onto the ALU inputs. The ALU
// result and flags are captured one cycle later and returned on a one-hot
// valid/ready response channel.
// Optional macro ALU_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of the default round-robin.
module alu_share_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [2*NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_result,
  output logic [3:0]             rsp_flags,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [1:0]             alu_control,
  input  logic [31:0]            alu_result,
  input  logic [3:0]             alu_flags,
  output logic                   busy
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_nx;
  logic [IW-1:0]      owner;
  logic [NUM_REQ-1:0] grant;
  logic [31:0]        sel_a, sel_b;
  logic [1:0]         sel_op;
  logic               found;
  logic               accept;
  logic               rsp_done;
  int unsigned        best_d, d, win;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IW-1:0]      last_grant;
`endif

  // Winner search: smallest priority distance among valid requesters.
  // Round-robin distance counts from the requester after last_grant.
  always_comb begin
    found  = 1'b0;
    best_d = NUM_REQ;
    win    = 0;
    d      = 0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      d = j;
`else
      d = (j + 2 * NUM_REQ - 1 - 32'(last_grant)) % NUM_REQ;
`endif
      if (req_valid[j] && (d < best_d)) begin
        best_d = d;
        win    = j;
        found  = 1'b1;
      end
    end
  end

  // One-hot grant and operand mux for the winner.
  always_comb begin
    grant  = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (found && (win == j)) begin
        grant[j] = 1'b1;
        sel_a    = req_a[32*j +: 32];
        sel_b    = req_b[32*j +: 32];
        sel_op   = req_op[2*j +: 2];
      end
    end
  end

  // Response channel: one-hot valid to the owner, owner's ready ends the op.
  always_comb begin
    rsp_valid = '0;
    rsp_done  = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (32'(owner) == j) begin
        rsp_valid[j] = (state == RESP);
        rsp_done     = rsp_ready[j];
      end
    end
  end

  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = (state == IDLE) && found;
  assign busy      = (state != IDLE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand registers and ownership, updated only on an accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      owner       <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant  <= IW'(NUM_REQ - 1);
`endif
    end else if (accept) begin
      alu_a       <= sel_a;
      alu_b       <= sel_b;
      alu_control <= sel_op;
      owner       <= IW'(win);
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant  <= IW'(win);
`endif
    end
  end

  // Capture ALU result and flags at the end of EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else if (state == EXEC) begin
      rsp_result <= alu_result;
      rsp_flags  <= alu_flags;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter with two requesters and a behavioural ALU.
module tb_alu_share_arbiter;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_op;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic [3:0]  rsp_flags, alu_flags;
  logic [1:0]  alu_control;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int last_g = N - 1;

  logic [31:0] ta [2];
  logic [31:0] tbv[2];
  logic [1:0]  top[2];

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .busy(busy)
  );

  // Reference ALU: returns {N,Z,C,V,result}; C on sub means no borrow.
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                   v = (a[31] == b[31]) && (r[31] != a[31]); end
      2'b01: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
                   v = (a[31] != b[31]) && (r[31] != a[31]); end
      2'b10: r = a & b;
      default: r = a | b;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_ref(alu_a, alu_b, alu_control);

  // Expected winner: round-robin from the requester after last_g, or lowest index.
  function automatic int pick(input logic [1:0] mask);
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (mask[k]) return k;
`else
    for (int k = 1; k <= N; k++) if (mask[(last_g + k) % N]) return (last_g + k) % N;
`endif
    return -1;
  endfunction

  task automatic drive_ops();
    req_a  = {ta[1], ta[0]};
    req_b  = {tbv[1], tbv[0]};
    req_op = {top[1], top[0]};
  endtask

  // One full transaction; pre must be non-zero. Ends in IDLE with req_valid low.
  task automatic do_txn(input logic [1:0] pre, input logic [1:0] post, input int stall,
                        output int w);
    logic [35:0] e;
    logic [1:0]  oh;
    w  = pick(pre);
    oh = (w == 0) ? 2'b01 : 2'b10;
    e  = alu_ref(ta[w], tbv[w], top[w]);
    drive_ops();
    req_valid = pre; rsp_ready = '0;
    #1;
    checks++;
    if (req_ready !== oh) begin errors++;
      $display("FAIL accept_ready: got %b expected %b", req_ready, oh); end
    @(negedge clk); req_valid = post; #1;
    checks++;
    if ({busy, req_ready, rsp_valid} !== 5'b1_00_00) begin errors++;
      $display("FAIL exec_state: busy/ready/rsp_valid got %b expected 10000",
               {busy, req_ready, rsp_valid}); end
    checks++;
    if ({alu_a, alu_b, alu_control} !== {ta[w], tbv[w], top[w]}) begin errors++;
      $display("FAIL alu_operands: got %h %h %b expected %h %h %b",
               alu_a, alu_b, alu_control, ta[w], tbv[w], top[w]); end
    @(negedge clk); #1;
    checks++;
    if ({rsp_valid, req_ready} !== {oh, 2'b00}) begin errors++;
      $display("FAIL rsp_valid: valid/ready got %b expected %b00", {rsp_valid, req_ready}, oh); end
    checks++;
    if ({rsp_flags, rsp_result} !== e) begin errors++;
      $display("FAIL rsp_data: got %b %h expected %b %h",
               rsp_flags, rsp_result, e[35:32], e[31:0]); end
    for (int s = 0; s < stall; s++) begin
      rsp_ready = ~oh;
      req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom}; req_op = 4'($urandom);
      @(negedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_flags, rsp_result, req_ready, alu_a, alu_b, busy} !==
          {oh, e, 2'b00, ta[w], tbv[w], 1'b1}) begin errors++;
        $display("FAIL rsp_hold: cycle %0d valid %b flags %b result %h ready %b alu_a %h expected %b %b %h 00 %h",
                 s, rsp_valid, rsp_flags, rsp_result, req_ready, alu_a, oh, e[35:32], e[31:0], ta[w]); end
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    rsp_ready = '0; req_valid = '0; #1;
    checks++;
    if ({rsp_valid, busy} !== 3'b000) begin errors++;
      $display("FAIL rsp_done: valid/busy got %b expected 000", {rsp_valid, busy}); end
    last_g = w;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    ta = '{32'h0, 32'h0}; tbv = '{32'h0, 32'h0}; top = '{2'b00, 2'b00};
    drive_ops();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, busy, rsp_result, rsp_flags} !== '0) begin errors++;
      $display("FAIL reset_outputs: ready %b valid %b busy %b result %h flags %b expected all zero",
               req_ready, rsp_valid, busy, rsp_result, rsp_flags); end
    checks++;
    if ({alu_a, alu_b, alu_control} !== '0) begin errors++;
      $display("FAIL reset_alu_regs: got %h %h %b expected zero", alu_a, alu_b, alu_control); end
    reset = 1'b0; last_g = N - 1;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_single_add();
    int w;
    ta[0] = 32'h0000_00FF; tbv[0] = 32'h0000_0001; top[0] = 2'b00;
    do_txn(2'b01, 2'b00, 0, w);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL single_add_winner: got %0d expected 0", w); end
  endtask

  task automatic test_sub_zero();
    int w;
    ta[1] = 32'h0000_0001; tbv[1] = 32'h0000_0001; top[1] = 2'b01;
    do_txn(2'b10, 2'b00, 1, w);
    checks++;
    if (w !== 1) begin errors++; $display("FAIL sub_zero_winner: got %0d expected 1", w); end
  endtask

  task automatic test_contention();
    int w;
    int order[4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0};
`else
    order = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 2; i++) begin
      ta[i] = 32'hFFFF_FFFF; tbv[i] = 32'h1234_5678; top[i] = 2'b10;
    end
    for (int i = 0; i < 4; i++) begin
      do_txn(2'b11, 2'b11, i % 2, w);
      checks++;
      if (w !== order[i]) begin errors++;
        $display("FAIL contention_order: op %0d got %0d expected %0d", i, w, order[i]); end
    end
  endtask

  task automatic test_backpressure();
    int w;
    ta[0] = 32'h1234_5678; tbv[0] = 32'h8765_4321; top[0] = 2'b11;
    ta[1] = 32'h7FFF_FFFF; tbv[1] = 32'h0000_0001; top[1] = 2'b00;
    do_txn(2'b01, 2'b11, 5, w);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL backpressure_winner: got %0d expected 0", w); end
    do_txn(2'b11, 2'b00, 0, w);
    checks++;
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (w !== 0) begin errors++; $display("FAIL after_backpressure_winner: got %0d expected 0", w); end
`else
    if (w !== 1) begin errors++; $display("FAIL after_backpressure_winner: got %0d expected 1", w); end
`endif
  endtask

  task automatic test_reset_mid_op();
    int w;
    ta[0] = 32'hDEAD_BEEF; tbv[0] = 32'h0000_1111; top[0] = 2'b01;
    drive_ops();
    req_valid = 2'b01;
    @(negedge clk);
    reset = 1'b1; req_valid = '0;
    @(negedge clk); #1;
    checks++;
    if ({busy, rsp_valid, req_ready, alu_a, alu_b, alu_control} !== '0) begin errors++;
      $display("FAIL reset_mid_op: busy %b valid %b ready %b alu %h %h %b expected all zero",
               busy, rsp_valid, req_ready, alu_a, alu_b, alu_control); end
    reset = 1'b0; last_g = N - 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({rsp_valid, busy} !== 3'b000) begin errors++;
      $display("FAIL no_dropped_rsp: valid/busy got %b expected 000", {rsp_valid, busy}); end
    ta[1] = 32'h8000_0000; tbv[1] = 32'h8000_0000; top[1] = 2'b00;
    do_txn(2'b10, 2'b00, 0, w);
    checks++;
    if (w !== 1) begin errors++; $display("FAIL post_reset_winner: got %0d expected 1", w); end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int w;
    logic [1:0] pre;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 2; k++) begin
        ta[k] = rand_operand(); tbv[k] = rand_operand(); top[k] = 2'($urandom_range(0, 3));
      end
      pre = 2'($urandom_range(0, 3));
      if (pre == 2'b00) begin
        drive_ops(); req_valid = '0; #1;
        checks++;
        if ({req_ready, busy} !== 3'b000) begin errors++;
          $display("FAIL idle_no_grant: ready/busy got %b expected 000", {req_ready, busy}); end
        @(negedge clk);
      end else begin
        do_txn(pre, 2'($urandom_range(0, 3)), $urandom_range(0, 3), w);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_add();
    test_sub_zero();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
